// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants and the sprite DMA state encoding.
// Used by the OAM DMA controller and by anything that must agree on its register addresses.
package nes_bus_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DMA_LEN = 256;
    localparam int unsigned IDX_W   = $clog2(DMA_LEN);
    localparam int unsigned PAGE_W  = ADDR_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ALIGN,
        READ,
        WRITE
    } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-core / CPU-bus signal bundle seen by the sprite DMA controller.
// The master modport is the DMA controller; the slave modport is the CPU core plus bus mux side.
interface oam_dma_ctrl_if;
    import nes_bus_pkg::*;

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rw;
    logic [DATA_W-1:0] cpu_dout;
    logic [DATA_W-1:0] bus_din;

    logic              rdy;
    logic              dma_active;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_rw;
    logic [DATA_W-1:0] dma_dout;

    modport master (
        input  cpu_addr,
        input  cpu_rw,
        input  cpu_dout,
        input  bus_din,
        output rdy,
        output dma_active,
        output dma_addr,
        output dma_rw,
        output dma_dout
    );

    modport slave (
        output cpu_addr,
        output cpu_rw,
        output cpu_dout,
        output bus_din,
        input  rdy,
        input  dma_active,
        input  dma_addr,
        input  dma_rw,
        input  dma_dout
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite (OAM) DMA controller: a $4014 write halts the CPU and copies one 256-byte page
// to OAMDATA using alternating get/put cycles. All outputs are registered.
module oam_dma_ctrl
    import nes_bus_pkg::*;
(
    input  logic           clk_cpu,
    input  logic           rst_cpu,
    oam_dma_ctrl_if.master bus
);

    oam_dma_state_t    r_state;
    logic              r_put;
    logic [IDX_W-1:0]  r_idx;
    logic [PAGE_W-1:0] r_page;
    logic [DATA_W-1:0] r_data;
    logic              r_rdy;
    logic              r_active;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;

    oam_dma_state_t    w_state_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [PAGE_W-1:0] w_page_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_rdy_nxt;
    logic              w_active_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_rw_nxt;
    logic              w_start;
    logic              w_last;

    assign w_start = (bus.cpu_addr == DMA_REG_ADDR) && !bus.cpu_rw;
    assign w_last  = (r_idx == IDX_W'(DMA_LEN - 1));

    // Next-state and next-output logic; outputs are derived from the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_page_nxt  = r_page;
        w_data_nxt  = r_data;

        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_page_nxt  = PAGE_W'(bus.cpu_dout);
                    w_idx_nxt   = '0;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // CPU write cycles ignore RDY, so the halt only lands on a read cycle.
                if (bus.cpu_rw) begin
                    w_state_nxt = r_put ? READ : ALIGN;
                end
            end
            ALIGN: begin
                w_state_nxt = READ;
            end
            READ: begin
                w_data_nxt  = bus.bus_din;
                w_state_nxt = WRITE;
            end
            WRITE: begin
                if (w_last) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = READ;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_rdy_nxt    = (w_state_nxt == IDLE);
        w_active_nxt = (w_state_nxt == READ) || (w_state_nxt == WRITE);
        w_rw_nxt     = (w_state_nxt != WRITE);
        w_addr_nxt   = '0;
        if (w_state_nxt == READ) begin
            w_addr_nxt = {w_page_nxt, w_idx_nxt};
        end else if (w_state_nxt == WRITE) begin
            w_addr_nxt = OAMDATA_ADDR;
        end
    end

    // State and output registers; put parity runs freely in every state.
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            r_state  <= IDLE;
            r_put    <= 1'b0;
            r_idx    <= '0;
            r_page   <= '0;
            r_data   <= '0;
            r_rdy    <= 1'b1;
            r_active <= 1'b0;
            r_addr   <= '0;
            r_rw     <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_put    <= ~r_put;
            r_idx    <= w_idx_nxt;
            r_page   <= w_page_nxt;
            r_data   <= w_data_nxt;
            r_rdy    <= w_rdy_nxt;
            r_active <= w_active_nxt;
            r_addr   <= w_addr_nxt;
            r_rw     <= w_rw_nxt;
        end
    end

    assign bus.rdy        = r_rdy;
    assign bus.dma_active = r_active;
    assign bus.dma_addr   = r_addr;
    assign bus.dma_rw     = r_rw;
    assign bus.dma_dout   = r_data;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed-plus-random bench for the sprite DMA controller; expectations come from
// transfer-level arithmetic (halt length, parity, page byte order) and a memory array.
module tb_oam_dma_ctrl;
    import nes_bus_pkg::*;

    logic clk_cpu = 1'b0;
    logic rst_cpu = 1'b1;

    oam_dma_ctrl_if ifc ();

    oam_dma_ctrl dut (
        .clk_cpu (clk_cpu),
        .rst_cpu (rst_cpu),
        .bus     (ifc)
    );

    always #5 clk_cpu = ~clk_cpu;

    logic [7:0] mem [0:65535];
    assign ifc.bus_din = mem[ifc.dma_addr];

    int nvec  = 0;
    int nfail = 0;
    bit tb_put = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
        ifc.cpu_addr = a;
        ifc.cpu_rw   = rw;
        ifc.cpu_dout = d;
    endtask

    // Advance one cycle; tb_put is the parity of the cycle now beginning.
    task automatic step();
        @(posedge clk_cpu);
        #1;
        if (rst_cpu) tb_put = 1'b0;
        else         tb_put = ~tb_put;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy"},    32'(ifc.rdy),        32'd1);
        check({tag, "_active"}, 32'(ifc.dma_active), 32'd0);
        check({tag, "_rw"},     32'(ifc.dma_rw),     32'd1);
    endtask

    // One transfer: optional extra CPU writes in REQ, chosen start parity, optional reset at a WRITE idx.
    task automatic run_dma(input logic [7:0] page, input int w, input bit want_put, input int rst_at);
        int          lows;
        int          ops;
        int          exp_lows;
        int          first_active;
        int          i;
        bit          align;
        logic [15:0] ea;

        cpu_drive(16'($urandom), 1'b1, 8'($urandom));
        if (tb_put != want_put) step();

        cpu_drive(DMA_REG_ADDR, 1'b0, page);
        step();
        lows = 1;
        check("rdy_fall", 32'(ifc.rdy), 32'd0);
        check("req_inactive", 32'(ifc.dma_active), 32'd0);

        for (int k = 0; k < w; k++) begin
            cpu_drive((k == 0) ? DMA_REG_ADDR : 16'($urandom), 1'b0, ~page);
            step();
            lows++;
            check("req_hold_rdy", 32'(ifc.rdy), 32'd0);
            check("req_hold_inactive", 32'(ifc.dma_active), 32'd0);
        end

        cpu_drive(16'($urandom), 1'b1, 8'($urandom));
        align        = (tb_put == 1'b0);
        exp_lows     = 1 + w + int'(align) + 2 * int'(DMA_LEN);
        first_active = lows + int'(align) + 1;
        ops          = 0;

        for (int n = 0; n < 700; n++) begin
            step();
            if (ifc.rdy) break;
            lows++;
            if (ifc.dma_active) begin
                if (ops == 0) check("first_active_cycle", 32'(lows), 32'(first_active));
                i  = ops / 2;
                ea = {page, 8'(i)};
                if ((ops % 2) == 0) begin
                    check("get_addr", 32'(ifc.dma_addr), 32'(ea));
                    check("get_rw",   32'(ifc.dma_rw),   32'd1);
                end else begin
                    check("put_addr", 32'(ifc.dma_addr), 32'(OAMDATA_ADDR));
                    check("put_rw",   32'(ifc.dma_rw),   32'd0);
                    check("put_data", 32'(ifc.dma_dout), 32'(mem[ea]));
                end
                ops++;
                cpu_drive(16'($urandom), 1'($urandom), 8'($urandom));
                if (rst_at >= 0 && ops == 2 * rst_at + 2) begin
                    rst_cpu = 1'b1;
                    cpu_drive(DMA_REG_ADDR, 1'b0, 8'h55);
                    step();
                    rst_cpu = 1'b0;
                    check_idle_outputs("mid_reset");
                    check("mid_reset_addr", 32'(ifc.dma_addr), 32'd0);
                    check("mid_reset_dout", 32'(ifc.dma_dout), 32'd0);
                    cpu_drive(16'($urandom), 1'b1, 8'($urandom));
                    step();
                    check_idle_outputs("reset_beats_start");
                    return;
                end
            end else begin
                check("no_gap_before_done", 32'(ops), 32'd0);
            end
        end

        check("rdy_low_cycles", 32'(lows), 32'(exp_lows));
        check("op_count", 32'(ops), 32'(2 * DMA_LEN));
        check_idle_outputs("done");
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int a = 0; a < 256; a++) mem[16'h0300 + a] = 8'(a) ^ 8'hA5;

        cpu_drive(16'h0000, 1'b1, 8'h00);
        rst_cpu = 1'b1;
        step();
        step();
        check_idle_outputs("reset");
        check("reset_addr", 32'(ifc.dma_addr), 32'd0);
        check("reset_dout", 32'(ifc.dma_dout), 32'd0);
        rst_cpu = 1'b0;

        // Start on a get cycle, then on a put cycle.
        run_dma(8'h02, 0, 1'b0, -1);
        run_dma(8'h02, 0, 1'b1, -1);

        // Known pattern page: put data must be i^A5 in order.
        run_dma(8'h03, 0, 1'($urandom), -1);
        for (int a = 0; a < 4; a++) check("pattern_mem", 32'(mem[16'h0300 + a]), 32'(8'(a) ^ 8'hA5));

        // Two extra CPU writes while waiting for the halt, both parities.
        run_dma(8'($urandom), 2, 1'b0, -1);
        run_dma(8'($urandom), 2, 1'b1, -1);

        // Reset while writing idx 100, then a fresh transfer from $0700.
        run_dma(8'h11, 0, 1'b0, 100);
        run_dma(8'h07, 0, 1'($urandom), -1);

        // Top page is legal.
        run_dma(8'hFF, 1, 1'($urandom), -1);

        // Random pages, REQ stretches and parities.
        for (int r = 0; r < 3; r++) begin
            run_dma(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), -1);
        end

        // Non-start accesses: write $4015, read $4014.
        cpu_drive(16'h4015, 1'b0, 8'h0F);
        step();
        check_idle_outputs("write_4015");
        cpu_drive(DMA_REG_ADDR, 1'b1, 8'h02);
        step();
        check_idle_outputs("read_4014");
        cpu_drive(16'h0000, 1'b1, 8'h00);
        step();
        check_idle_outputs("after_non_start");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
